// File: rtl/lfsr_pkg.sv
// Shared types, maximal-length tap masks and the single-shift step for the LFSR stream.
// Tap bit i set means state[i] feeds the XOR; feedback enters at bit 0.
package lfsr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int LFSR_MAX_W = 64;

  // Two-/four-tap maximal-length polynomials (or their reciprocals, equally maximal).
  localparam logic [2:0]  TAPS_W3  = 3'b110;
  localparam logic [3:0]  TAPS_W4  = 4'b1100;
  localparam logic [4:0]  TAPS_W5  = 5'b10010;
  localparam logic [5:0]  TAPS_W6  = 6'b110000;
  localparam logic [6:0]  TAPS_W7  = 7'b1100000;
  localparam logic [7:0]  TAPS_W8  = 8'b10111000;
  localparam logic [15:0] TAPS_W16 = 16'hD008;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;
  localparam logic [63:0] TAPS_W64 = 64'hD800_0000_0000_0000;

  // Operates on a zero-extended state; the caller truncates back to its width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_shift(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return {state[LFSR_MAX_W-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_advance.sv
// Combinational STEP-fold LFSR advance: applies STEP single shifts in one cycle.
module lfsr_advance
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_W5,
  parameter int               STEP  = 1
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_state
);

  logic [WIDTH-1:0] w_chain [STEP+1];

  assign w_chain[0] = i_state;

  for (genvar gi = 0; gi < STEP; gi++) begin : g_shift
    assign w_chain[gi+1] = WIDTH'(lfsr_shift(LFSR_MAX_W'(w_chain[gi]), LFSR_MAX_W'(TAPS)));
  end

  assign o_state = w_chain[STEP];

endmodule

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR word source with valid/ready output, seed loading and period detection.
// The state register is the output word; each handshake advances it by STEP shifts.
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_W5,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
  parameter int               STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  output logic             seed_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             lock_err
);

  state_t           r_fsm;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic             r_wrap;
  logic             r_lock_err;

  logic [WIDTH-1:0] w_adv;
  logic             w_hs;
  logic             w_seed_zero;

  lfsr_advance #(
    .WIDTH(WIDTH),
    .TAPS (TAPS),
    .STEP (STEP)
  ) u_advance (
    .i_state(r_lfsr),
    .o_state(w_adv)
  );

  assign w_hs        = r_out_valid & out_ready;
  assign w_seed_zero = (seed_data == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm       <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_lfsr      <= SEED;
      r_seed      <= SEED;
      r_count     <= '0;
      r_period    <= '0;
      r_wrap      <= 1'b0;
      r_lock_err  <= 1'b0;
    end else begin
      r_wrap     <= 1'b0;
      r_lock_err <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          // A load wins over en; RUN can only start on the following cycle.
          if (seed_valid) begin
            r_lfsr     <= w_seed_zero ? SEED : seed_data;
            r_seed     <= w_seed_zero ? SEED : seed_data;
            r_count    <= '0;
            r_lock_err <= w_seed_zero;
          end else if (en) begin
            r_fsm       <= ST_RUN;
            r_out_valid <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_hs) begin
            r_lfsr <= w_adv;
            if (w_adv == r_seed) begin
              r_wrap   <= 1'b1;
              r_period <= r_count + 1'b1;
              r_count  <= '0;
            end else begin
              r_count <= r_count + 1'b1;
            end
            // Leaving RUN only on a handshake keeps valid from dropping mid-offer.
            if (!en) begin
              r_fsm       <= ST_IDLE;
              r_out_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_fsm       <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign seed_ready = (r_fsm == ST_IDLE);
  assign out_valid  = r_out_valid;
  assign out_data   = r_lfsr;
  assign wrap       = r_wrap;
  assign period     = r_period;
  assign lock_err   = r_lock_err;

endmodule

// File: tb/tb_lfsr_stream.sv
// Directed bench for lfsr_stream: default x^5+x^3+1 instance plus a STEP=2 instance.
module tb_lfsr_stream;

  logic       clk;
  logic       reset;
  logic       en;
  logic       seed_valid;
  logic [4:0] seed_data;
  logic       seed_ready;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_data;
  logic       wrap;
  logic [4:0] period;
  logic       lock_err;

  logic       rst2;
  logic       en2;
  logic       seed_valid2;
  logic [4:0] seed_data2;
  logic       seed_ready2;
  logic       out_valid2;
  logic       out_ready2;
  logic [4:0] out_data2;
  logic       wrap2;
  logic [4:0] period2;
  logic       lock_err2;

  int n_cmp;
  int n_err;

  lfsr_stream #(.WIDTH(5), .TAPS(5'b10010), .SEED(5'h1f), .STEP(1)) u_dut (
    .clk(clk), .reset(reset), .en(en), .seed_valid(seed_valid), .seed_data(seed_data),
    .seed_ready(seed_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .wrap(wrap), .period(period), .lock_err(lock_err)
  );

  lfsr_stream #(.WIDTH(5), .TAPS(5'b10010), .SEED(5'h1f), .STEP(2)) u_dut2 (
    .clk(clk), .reset(rst2), .en(en2), .seed_valid(seed_valid2), .seed_data(seed_data2),
    .seed_ready(seed_ready2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .wrap(wrap2), .period(period2), .lock_err(lock_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || seed_ready !== 1'b1 || wrap !== 1'b0 || lock_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: valid=%b ready=%b wrap=%b lock=%b want 0 1 0 0",
               out_valid, seed_ready, wrap, lock_err);
    end
    n_cmp++;
    if (out_data !== 5'h1f || period !== 5'h00) begin
      n_err++;
      $display("FAIL reset_regs: data=%h period=%0d want 1f 0", out_data, period);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_hold: valid=%b want 0", out_valid);
    end
    $display("reset: data=%h valid=%b", out_data, out_valid);
  endtask

  task automatic test_sequence();
    logic [4:0] exp_seq [5] = '{5'h1f, 5'h1e, 5'h1c, 5'h19, 5'h13};
    en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin
        n_err++;
        $display("FAIL seq[%0d]: valid=%b data=%h want 1 %h", i, out_valid, out_data, exp_seq[i]);
      end
      $display("seq[%0d]: data=%h", i, out_data);
    end
  endtask

  task automatic test_wrap();
    int n_wrap = 0;
    for (int i = 0; i < 26; i++) begin
      tick();
      if (wrap === 1'b1) n_wrap++;
    end
    n_cmp++;
    if (n_wrap != 0) begin
      n_err++;
      $display("FAIL early_wrap: pulses=%0d want 0", n_wrap);
    end
    tick();
    n_cmp++;
    if (wrap !== 1'b1 || out_data !== 5'h1f || period !== 5'd31) begin
      n_err++;
      $display("FAIL wrap31: wrap=%b data=%h period=%0d want 1 1f 31", wrap, out_data, period);
    end
    $display("wrap: wrap=%b data=%h period=%0d", wrap, out_data, period);
    tick();
    n_cmp++;
    if (wrap !== 1'b0 || out_data !== 5'h1e || period !== 5'd31) begin
      n_err++;
      $display("FAIL wrap_pulse: wrap=%b data=%h period=%0d want 0 1e 31", wrap, out_data, period);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 5'h1e) begin
        n_err++;
        $display("FAIL stall[%0d]: valid=%b data=%h want 1 1e", i, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (out_data !== 5'h1c) begin
      n_err++;
      $display("FAIL resume0: data=%h want 1c", out_data);
    end
    tick();
    n_cmp++;
    if (out_data !== 5'h19) begin
      n_err++;
      $display("FAIL resume1: data=%h want 19", out_data);
    end
    $display("stall: resumed data=%h", out_data);
  endtask

  task automatic test_en_drop();
    out_ready  = 1'b0;
    en         = 1'b0;
    seed_valid = 1'b1;
    seed_data  = 5'h0a;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 5'h19 || seed_ready !== 1'b0) begin
        n_err++;
        $display("FAIL en_drop_hold[%0d]: valid=%b data=%h sready=%b want 1 19 0",
                 i, out_valid, out_data, seed_ready);
      end
    end
    seed_valid = 1'b0;
    seed_data  = 5'h00;
    out_ready  = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 5'h13 || seed_ready !== 1'b1) begin
      n_err++;
      $display("FAIL en_drop_idle: valid=%b data=%h sready=%b want 0 13 1",
               out_valid, out_data, seed_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 5'h13) begin
      n_err++;
      $display("FAIL idle_stable: valid=%b data=%h want 0 13", out_valid, out_data);
    end
    $display("en_drop: data=%h valid=%b", out_data, out_valid);
  endtask

  task automatic test_zero_seed();
    int n_wrap = 0;
    seed_valid = 1'b1;
    seed_data  = 5'h00;
    tick();
    n_cmp++;
    if (lock_err !== 1'b1 || out_data !== 5'h1f || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL zero_seed: lock=%b data=%h valid=%b want 1 1f 0", lock_err, out_data, out_valid);
    end
    seed_valid = 1'b0;
    en = 1'b1;
    tick();
    n_cmp++;
    if (lock_err !== 1'b0 || out_valid !== 1'b1 || out_data !== 5'h1f) begin
      n_err++;
      $display("FAIL zero_seed_run: lock=%b valid=%b data=%h want 0 1 1f", lock_err, out_valid, out_data);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (wrap === 1'b1) n_wrap++;
    end
    tick();
    n_cmp++;
    if (n_wrap != 0 || wrap !== 1'b1 || period !== 5'd31 || out_data !== 5'h1f) begin
      n_err++;
      $display("FAIL zero_seed_period: early=%0d wrap=%b period=%0d data=%h want 0 1 31 1f",
               n_wrap, wrap, period, out_data);
    end
    $display("zero_seed: period=%0d", period);
    en = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 5'h1e) begin
      n_err++;
      $display("FAIL to_idle: valid=%b data=%h want 0 1e", out_valid, out_data);
    end
  endtask

  task automatic test_seed_load();
    int n_wrap = 0;
    seed_valid = 1'b1;
    seed_data  = 5'h0a;
    en         = 1'b1;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 5'h0a || lock_err !== 1'b0) begin
      n_err++;
      $display("FAIL load: valid=%b data=%h lock=%b want 0 0a 0", out_valid, out_data, lock_err);
    end
    seed_valid = 1'b0;
    seed_data  = 5'h00;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 5'h0a) begin
      n_err++;
      $display("FAIL load_run: valid=%b data=%h want 1 0a", out_valid, out_data);
    end
    tick();
    n_cmp++;
    if (out_data !== 5'h15) begin
      n_err++;
      $display("FAIL load_adv0: data=%h want 15", out_data);
    end
    tick();
    n_cmp++;
    if (out_data !== 5'h0b) begin
      n_err++;
      $display("FAIL load_adv1: data=%h want 0b", out_data);
    end
    for (int i = 0; i < 28; i++) begin
      tick();
      if (wrap === 1'b1) n_wrap++;
    end
    tick();
    n_cmp++;
    if (n_wrap != 0 || wrap !== 1'b1 || out_data !== 5'h0a || period !== 5'd31) begin
      n_err++;
      $display("FAIL load_wrap: early=%0d wrap=%b data=%h period=%0d want 0 1 0a 31",
               n_wrap, wrap, out_data, period);
    end
    $display("seed_load: wrap data=%h period=%0d", out_data, period);
  endtask

  task automatic test_step2();
    logic [4:0] exp_seq [3] = '{5'h1f, 5'h1c, 5'h13};
    rst2 = 1'b0;
    en2 = 1'b1;
    out_ready2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (out_valid2 !== 1'b1 || out_data2 !== exp_seq[i]) begin
        n_err++;
        $display("FAIL step2[%0d]: valid=%b data=%h want 1 %h", i, out_valid2, out_data2, exp_seq[i]);
      end
      $display("step2[%0d]: data=%h", i, out_data2);
    end
    #2;
    rst2 = 1'b1;
    #1;
    n_cmp++;
    if (out_valid2 !== 1'b0 || out_data2 !== 5'h1f || seed_ready2 !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: valid=%b data=%h sready=%b want 0 1f 1",
               out_valid2, out_data2, seed_ready2);
    end
    $display("async_reset: data=%h valid=%b", out_data2, out_valid2);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    en = 1'b0;
    seed_valid = 1'b0;
    seed_data = 5'h00;
    out_ready = 1'b0;
    rst2 = 1'b1;
    en2 = 1'b0;
    seed_valid2 = 1'b0;
    seed_data2 = 5'h00;
    out_ready2 = 1'b0;

    test_reset();
    test_sequence();
    test_wrap();
    test_stall();
    test_en_drop();
    test_zero_seed();
    test_seed_load();
    test_step2();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_stream.md
# lfsr_stream

Parametrised Fibonacci LFSR pseudo-random source with a valid/ready output stream, run-time seed loading, multi-shift advance per word and sequence-period detection. It supersedes the fixed 5-bit LFSRs in the TRNG area and feeds downstream consumers (LED pattern and whitening logic) at up to one word per clock.

## Interface
- WIDTH, 5: state and output word width, 3..64.
- TAPS, 5'b10010: feedback mask; bit i set means state[i] enters the XOR. The default gives x^5+x^3+1, period 31.
- SEED, all ones: reset seed and substitute for an all-zero loaded seed.
- STEP, 1: shifts applied per accepted word, 1..WIDTH.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset. Clock and reset form the only clock/reset pair.
- en  in  1  run request.
- seed_valid  in  1  seed load request.
- seed_data  in  WIDTH  seed value.
- seed_ready  out  1  high only in IDLE.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accept.
- out_data  out  WIDTH  current LFSR state.
- wrap  out  1  one-cycle pulse when the sequence returns to the active seed.
- period  out  WIDTH  word count of the last completed cycle; holds until the next wrap.
- lock_err  out  1  one-cycle pulse when an all-zero seed load is substituted.

## Operation
- One shift: fb = XOR of (state & TAPS); state_next = {state[WIDTH-2:0], fb}.
- Advance: STEP consecutive shifts, evaluated combinationally in one cycle.
- out_data is the state register. A handshake (out_valid & out_ready) advances the state by one STEP.
- FSM states are IDLE and RUN.
  - IDLE: out_valid=0, seed_ready=1.
  - IDLE -> RUN when en=1 and seed_valid=0.
  - RUN: out_valid=1, seed_ready=0.
  - RUN -> IDLE on a handshake while en=0. With en=0 and no handshake, RUN holds: out_valid never drops without a handshake, and out_data is stable while stalled.
- Seed load (IDLE & seed_valid):
  - state <= seed_data, or SEED if seed_data==0, in which case lock_err pulses.
  - The loaded value becomes the active seed; the word counter clears.
  - The FSM stays in IDLE that cycle: a load beats en, and RUN starts the cycle after.
- Word counter (WIDTH bits) increments on each handshake.
  - When the advanced state equals the active seed: wrap pulses, period <= counter+1, counter clears.
  - Counter wrap-around at 2^WIDTH is allowed; it only happens with non-primitive TAPS.
- Reset values:
  - state=SEED, active seed=SEED, FSM=IDLE.
  - out_valid=0, seed_ready=1, wrap=0, lock_err=0, period=0, counter=0.
- Reset mid-stream aborts immediately; the pending word is discarded.
- seed_valid in RUN is ignored; seed_ready=0 there.

## Timing
- en rising in IDLE -> out_valid=1 at the next clk edge.
- Throughput: one word per cycle with out_ready held high.
- Handshake at edge k -> new out_data visible after edge k.
- wrap and period update at the same edge as the handshake that returns the state to the seed. wrap is high for exactly one cycle.
- Seed load at edge k -> out_data=seed after edge k; the earliest out_valid is after edge k+1.
- lock_err is high for the single cycle after the substituting load.
- All outputs are registered except seed_ready, which is decoded from the FSM register.

## Structure
- Package lfsr_pkg holds:
  - the FSM state enum (IDLE, RUN);
  - default TAPS constants for WIDTH 3..8, 16, 32, 64 (maximal-length polynomials);
  - the single-shift function.
- Sub-module lfsr_advance: purely combinational, parameters WIDTH/TAPS/STEP, input state, output state advanced STEP shifts. It is instantiated once in lfsr_stream.

## Test plan
- Reset, then en=1, out_ready=1, defaults -> out_valid after one edge; out_data sequence 1f, 1e, 1c, 19, 13.
- Continuous accept for 31 words, defaults -> out_data back to 1f; wrap pulses once; period=31.
- In IDLE, seed_valid=1, seed_data=0 -> lock_err pulses; out_data=1f; next wrap gives period=31.
- out_ready low for 5 cycles mid-run -> out_valid stays 1 and out_data stays constant; the sequence resumes unbroken.
- en dropped while stalled -> remains RUN until the handshake, then IDLE (out_valid=0); seed_valid during RUN ignored.
- STEP=2, seed 1f -> out_data 1f, 1c, 13; reset asserted mid-run -> out_valid=0 and out_data=1f immediately.
